// File: rtl/bp_dec_intlv_pkg.sv
// Shared constants and helpers for the interleaved (4,3,7) Berlekamp-Preparata decoder.
package bp_dec_intlv_pkg;

  localparam int RATE_K = 3;
  localparam int RATE_N = 4;

  localparam int TAP1   = 1;
  localparam int TAP2   = 2;
  localparam int TAP3   = 3;
  localparam int TAP5   = 5;
  localparam int TAP6   = 6;
  localparam int TAP7   = 7;
  localparam int SYN_E0 = 4;
  localparam int SEGS   = 6;

  function automatic int latency(input int intlv);
    return TAP7 * intlv;
  endfunction

  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

endpackage

// File: rtl/bp_dec_intlv_if.sv
// Sample-in / decoded-out bundle for bp_dec_intlv; master drives the received samples.
interface bp_dec_intlv_if
  import bp_dec_intlv_pkg::*;
#(
  parameter int CNT_W = 16
);
  logic              ce;
  logic [RATE_N-1:0] r;
  logic              corr_en;
  logic              cnt_clr;
  logic [RATE_K-1:0] d;
  logic              out_valid;
  logic [RATE_K-1:0] err;
  logic [CNT_W-1:0]  err_cnt;

  modport master (
    output ce, r, corr_en, cnt_clr,
    input  d, out_valid, err, err_cnt
  );

  modport slave (
    input  ce, r, corr_en, cnt_clr,
    output d, out_valid, err, err_cnt
  );
endinterface

// File: rtl/bp_err_counter.sv
// Saturating accumulator of per-sample correction popcounts; clear beats increment.
module bp_err_counter
  import bp_dec_intlv_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [RATE_K-1:0] inc,
  output logic [CNT_W-1:0]  cnt
);
  logic [CNT_W:0] sum;

  // at most 3 per cycle, so a single carry bit is enough to detect overflow
  assign sum = {1'b0, cnt} + {{(CNT_W - 1){1'b0}}, popcount3(inc)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    end
  end
endmodule

// File: rtl/bp_dec_intlv.sv
// Interleaved (4,3,7) BP rate-3/4 burst-correcting decoder with fill tracking and error stats.
module bp_dec_intlv
  import bp_dec_intlv_pkg::*;
#(
  parameter int INTLV = 4,
  parameter int CNT_W = 16
) (
  input logic            clk,
  input logic            rst_n,
  bp_dec_intlv_if.slave  bus
);
  localparam int LAT    = latency(INTLV);
  localparam int SLEN   = SEGS * INTLV;
  localparam int FILL_W = $clog2(LAT + 1);

  logic [LAT:1]      r0_q, r1_q, r2_q;
  logic [SLEN:1]     s_q, s_d;
  logic [FILL_W-1:0] fill_q;
  logic              filled, s0, f;
  logic [RATE_K-1:0] e_raw;

  assign s0 = bus.r[RATE_N-1]
            ^ r2_q[TAP1*INTLV] ^ r1_q[TAP2*INTLV] ^ r0_q[TAP3*INTLV]
            ^ r0_q[TAP5*INTLV] ^ r0_q[TAP6*INTLV] ^ r1_q[TAP6*INTLV]
            ^ r0_q[TAP7*INTLV] ^ r1_q[TAP7*INTLV] ^ r2_q[TAP7*INTLV];

  // f low means the syndrome matches a correctable pattern for this interleave phase
  assign f = (s_q[TAP2*INTLV] ^ s_q[SYN_E0*INTLV])
           | s_q[TAP3*INTLV]
           | (s_q[TAP1*INTLV] ^ s_q[SYN_E0*INTLV] ^ s_q[TAP5*INTLV])
           | (s0 ^ s_q[SYN_E0*INTLV] ^ s_q[TAP5*INTLV] ^ s_q[TAP6*INTLV]);

  assign filled        = (fill_q == '0);
  assign e_raw         = {s_q[TAP6*INTLV], s_q[TAP5*INTLV], s_q[SYN_E0*INTLV]} & {RATE_K{~f}};
  assign bus.out_valid = bus.ce & filled;
  assign bus.err       = e_raw & {RATE_K{bus.corr_en & bus.out_valid}};
  assign bus.d         = {r2_q[LAT], r1_q[LAT], r0_q[LAT]} ^ bus.err;

  always_comb begin
    s_d = {s_q[SLEN-1:1], s0};
    for (int k = 0; k < SEGS; k++) begin
      s_d[k*INTLV+1] = s_d[k*INTLV+1] & f;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r0_q   <= '0;
      r1_q   <= '0;
      r2_q   <= '0;
      s_q    <= '0;
      fill_q <= FILL_W'(LAT);
    end else if (bus.ce) begin
      r0_q <= {r0_q[LAT-1:1], bus.r[0]};
      r1_q <= {r1_q[LAT-1:1], bus.r[1]};
      r2_q <= {r2_q[LAT-1:1], bus.r[2]};
      s_q  <= s_d;
      if (!filled) begin
        fill_q <= fill_q - 1'b1;
      end
    end
  end

  bp_err_counter #(
    .CNT_W (CNT_W)
  ) u_err_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.cnt_clr),
    .en    (bus.ce),
    .inc   (bus.err),
    .cnt   (bus.err_cnt)
  );
endmodule

// File: tb/tb_bp_dec_intlv.sv
// Directed bench: table of encoded streams with injected errors, plus reset and counter-clear sequences.
module tb_bp_dec_intlv;
  localparam int IA   = 4;
  localparam int IB   = 1;
  localparam int CWA  = 16;
  localparam int CWB  = 3;
  localparam int MAXN = 256;

  typedef struct {
    string      name;
    int         u;
    bit         rnd;
    bit         corr;
    int         e_start;
    int         e_cnt;
    int         e_step;
    logic [3:0] mask;
    bit         gaps;
    int         clr_at;
    int         n;
    int         exp_cnt;
  } scen_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bp_dec_intlv_if #(.CNT_W(CWA)) ifa ();
  bp_dec_intlv_if #(.CNT_W(CWB)) ifb ();

  bp_dec_intlv #(.INTLV(IA), .CNT_W(CWA)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  bp_dec_intlv #(.INTLV(IB), .CNT_W(CWB)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  int n_chk  = 0;
  int n_pass = 0;
  scen_t tbl[$];
  logic [2:0] tx [2][MAXN+1];
  logic [2:0] fl [2][MAXN+1];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic drive(input int u, input logic ce, input logic [3:0] r, input logic corr, input logic clr);
    if (u == 0) begin
      ifa.ce = ce; ifa.r = r; ifa.corr_en = corr; ifa.cnt_clr = clr;
    end else begin
      ifb.ce = ce; ifb.r = r; ifb.corr_en = corr; ifb.cnt_clr = clr;
    end
  endtask

  task automatic sample(input int u, output logic [2:0] d, output logic v, output logic [2:0] e,
                        output logic [31:0] c);
    if (u == 0) begin
      d = ifa.d; v = ifa.out_valid; e = ifa.err; c = 32'(ifa.err_cnt);
    end else begin
      d = ifb.d; v = ifb.out_valid; e = ifb.err; c = 32'(ifb.err_cnt);
    end
  endtask

  function automatic scen_t mk(input string nm, input int u, input bit rnd, input bit corr,
                               input int es, input int ec, input int st, input logic [3:0] mk_,
                               input bit gaps, input int clr, input int n, input int exp);
    scen_t s;
    s.name = nm; s.u = u; s.rnd = rnd; s.corr = corr; s.e_start = es; s.e_cnt = ec;
    s.e_step = st; s.mask = mk_; s.gaps = gaps; s.clr_at = clr; s.n = n; s.exp_cnt = exp;
    return s;
  endfunction

  function automatic logic bit_at(input int u, input int k, input int b);
    logic [2:0] w;
    if (k < 1) return 1'b0;
    w = tx[u][k];
    return w[b];
  endfunction

  // systematic encoder: parity chosen so the decoder sees a zero syndrome on clean data
  function automatic logic parity(input int u, input int n, input int i);
    return bit_at(u, n-i, 2) ^ bit_at(u, n-2*i, 1) ^ bit_at(u, n-3*i, 0)
         ^ bit_at(u, n-5*i, 0) ^ bit_at(u, n-6*i, 0) ^ bit_at(u, n-6*i, 1)
         ^ bit_at(u, n-7*i, 0) ^ bit_at(u, n-7*i, 1) ^ bit_at(u, n-7*i, 2);
  endfunction

  function automatic bit hit(input scen_t sc, input int n);
    if (sc.e_cnt == 0 || n < sc.e_start) return 1'b0;
    return ((n - sc.e_start) % sc.e_step == 0) && ((n - sc.e_start) / sc.e_step < sc.e_cnt);
  endfunction

  task automatic do_reset();
    logic [2:0] d, e; logic v; logic [31:0] c;
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 1'b1, 4'd0, 1'b1, 1'b0);
    drive(1, 1'b1, 4'd0, 1'b1, 1'b0);
    #1; sample(0, d, v, e, c);
    check("reset d", 32'(d), 32'd0);
    check("reset out_valid", 32'(v), 32'd0);
    check("reset err", 32'(e), 32'd0);
    check("reset err_cnt", c, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 1'b0, 4'd0, 1'b1, 1'b0);
    drive(1, 1'b0, 4'd0, 1'b1, 1'b0);
  endtask

  task automatic run_stream(input scen_t sc);
    int n, cyc, lat, ii, k;
    logic [2:0] data, d, e, ed, ee;
    logic [3:0] m;
    logic p, v, ev;
    logic [31:0] c;
    ii  = (sc.u == 0) ? IA : IB;
    lat = 7 * ii;
    for (int j = 0; j <= MAXN; j++) begin
      tx[sc.u][j] = '0;
      fl[sc.u][j] = '0;
    end
    n = 0; cyc = 0;
    while (n < sc.n && cyc < 4 * sc.n) begin
      cyc++;
      @(negedge clk);
      if (sc.gaps && $urandom_range(0, 3) == 0) begin
        drive(sc.u, 1'b0, 4'($urandom_range(0, 15)), sc.corr, 1'b0);
        #1; sample(sc.u, d, v, e, c);
        check($sformatf("%s stall out_valid n=%0d", sc.name, n), 32'(v), 32'd0);
        check($sformatf("%s stall err n=%0d", sc.name, n), 32'(e), 32'd0);
      end else begin
        n++;
        data = sc.rnd ? 3'($urandom_range(0, 7)) : 3'd0;
        tx[sc.u][n] = data;
        p = parity(sc.u, n, ii);
        m = hit(sc, n) ? sc.mask : 4'd0;
        fl[sc.u][n] = m[2:0];
        drive(sc.u, 1'b1, {p, data} ^ m, sc.corr, 1'(n == sc.clr_at));
        #1; sample(sc.u, d, v, e, c);
        ev = (n > lat);
        ed = '0; ee = '0;
        if (ev) begin
          k  = n - lat;
          ee = sc.corr ? fl[sc.u][k] : 3'd0;
          ed = tx[sc.u][k] ^ (sc.corr ? 3'd0 : fl[sc.u][k]);
        end
        check($sformatf("%s out_valid n=%0d", sc.name, n), 32'(v), 32'(ev));
        check($sformatf("%s d n=%0d", sc.name, n), 32'(d), 32'(ed));
        check($sformatf("%s err n=%0d", sc.name, n), 32'(e), 32'(ee));
      end
    end
    check($sformatf("%s sample budget", sc.name), 32'(n), 32'(sc.n));
    @(negedge clk);
    drive(sc.u, 1'b0, 4'd0, sc.corr, 1'b0);
    #1; sample(sc.u, d, v, e, c);
    check($sformatf("%s err_cnt", sc.name), c, 32'(sc.exp_cnt));
  endtask

  initial begin
    logic [2:0] d, e; logic v; logic [31:0] c;
    scen_t pre, post;
    rst_n = 1'b0;
    drive(0, 1'b0, 4'd0, 1'b1, 1'b0);
    drive(1, 1'b0, 4'd0, 1'b1, 1'b0);

    //           name                  u rnd corr start cnt step mask    gaps clr  n    exp
    tbl.push_back(mk("zero_clean",      0, 0, 1,  0,  0, 1, 4'b0000, 0,  0, 200,  0));
    tbl.push_back(mk("zero_single_r0",  0, 0, 1, 40,  1, 1, 4'b0001, 0,  0, 120,  1));
    tbl.push_back(mk("zero_burst",      0, 0, 1, 50,  4, 1, 4'b1111, 0,  0, 120, 12));
    tbl.push_back(mk("zero_burst_raw",  0, 0, 0, 50,  4, 1, 4'b1111, 0,  0, 120,  0));
    tbl.push_back(mk("rand_burst",      0, 1, 1, 50,  4, 1, 4'b1111, 0,  0, 120, 12));
    tbl.push_back(mk("rand_burst_gaps", 0, 1, 1, 50,  4, 1, 4'b1111, 1,  0, 120, 12));
    tbl.push_back(mk("rand_r2_gaps",    0, 1, 1, 45,  1, 1, 4'b0100, 1,  0, 120,  1));
    tbl.push_back(mk("rand_parity",     0, 1, 1, 30,  4, 1, 4'b1000, 0,  0, 120,  0));
    tbl.push_back(mk("rand_two_bit",    0, 1, 1, 60,  1, 1, 4'b0110, 0,  0, 120,  2));
    tbl.push_back(mk("rand_r1_raw",     0, 1, 0, 30,  4, 1, 4'b0010, 0,  0, 120,  0));
    tbl.push_back(mk("clr_same_cycle",  0, 0, 1, 40,  1, 1, 4'b0001, 0, 68, 120,  0));
    tbl.push_back(mk("clr_mid_burst",   0, 1, 1, 50,  4, 1, 4'b1111, 0, 79, 120,  6));
    tbl.push_back(mk("i1_spaced_sat",   1, 1, 1, 10, 10, 8, 4'b0010, 0,  0, 100,  7));

    for (int i = 0; i < tbl.size(); i++) begin
      do_reset();
      run_stream(tbl[i]);
    end

    // saturated narrow counter must return to zero on cnt_clr
    @(negedge clk);
    drive(1, 1'b1, 4'd0, 1'b1, 1'b1);
    @(negedge clk);
    drive(1, 1'b0, 4'd0, 1'b1, 1'b0);
    #1; sample(1, d, v, e, c);
    check("i1 cnt_clr", c, 32'd0);

    // asynchronous reset with a full pipeline, then refill under random stalls
    pre  = mk("pre_reset",  0, 1, 1, 20, 4, 1, 4'b1111, 0, 0, 60, 12);
    post = mk("post_reset", 0, 1, 1,  5, 4, 1, 4'b1111, 1, 0, 45, 12);
    do_reset();
    run_stream(pre);
    @(negedge clk);
    drive(0, 1'b1, 4'd0, 1'b1, 1'b0);
    #1; sample(0, d, v, e, c);
    check("pre-reset out_valid", 32'(v), 32'd1);
    #2; rst_n = 1'b0;
    #1; sample(0, d, v, e, c);
    check("async reset d", 32'(d), 32'd0);
    check("async reset out_valid", 32'(v), 32'd0);
    check("async reset err", 32'(e), 32'd0);
    check("async reset err_cnt", c, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 1'b0, 4'd0, 1'b1, 1'b0);
    run_stream(post);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_chk);
    $fatal(1, "watchdog");
  end
endmodule
